// File: rtl/input_conditioner.sv
// Board-input front end: 2-flop sync, per-button debounce FSM with press strobe,
// and a shared-window debouncer that updates the switch bus atomically.
module input_conditioner #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned N_SW            = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw_stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressChk,
    StPressed,
    StReleaseChk
  } btn_state_e;

  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [N_SW-1:0]  sw_meta_q, sw_sync_q;

  btn_state_e       state_q [N_BTN];
  btn_state_e       state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;

  logic [N_SW-1:0]  sw_cand_q, sw_cand_d;
  logic [N_SW-1:0]  sw_stable_q, sw_stable_d;
  logic [CW-1:0]    scnt_q, scnt_d;

  // First synchroniser stage feeds nothing but the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StReleased: begin
          if (btn_sync_q[i]) begin
            state_d[i] = StPressChk;
            cnt_d[i]   = '0;
          end
        end
        StPressChk: begin
          if (!btn_sync_q[i]) begin
            state_d[i] = StReleased;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StPressed;
            level_d[i] = 1'b1;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        StPressed: begin
          if (!btn_sync_q[i]) begin
            state_d[i] = StReleaseChk;
            cnt_d[i]   = '0;
          end
        end
        StReleaseChk: begin
          if (btn_sync_q[i]) begin
            state_d[i] = StPressed;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StReleased;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      endcase
    end
  end

  // Any change against the candidate restarts the window; the whole bus commits together.
  always_comb begin
    sw_cand_d   = sw_cand_q;
    sw_stable_d = sw_stable_q;
    scnt_d      = scnt_q;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_d = sw_sync_q;
      scnt_d    = '0;
    end else if (sw_cand_q != sw_stable_q) begin
      if (scnt_q == CntMax) begin
        sw_stable_d = sw_cand_q;
        scnt_d      = '0;
      end else begin
        scnt_d = scnt_q + CW'(1);
      end
    end else begin
      scnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
      level_q     <= '0;
      pulse_q     <= '0;
      sw_cand_q   <= '0;
      sw_stable_q <= '0;
      scnt_q      <= '0;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      sw_cand_q   <= sw_cand_d;
      sw_stable_q <= sw_stable_d;
      scnt_q      <= scnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign sw_stable = sw_stable_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 (latency 7 edges).
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [7:0] sw_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_pulse;
  logic [7:0] sw_stable;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;
  int bad_sw;

  input_conditioner #(
    .N_BTN          (2),
    .N_SW           (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .sw_stable(sw_stable)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with everything asserted, then a press seen from reset release
    rst_n   = 1'b0;
    btn_raw = 2'b11;
    sw_raw  = 8'hFF;
    tick();
    tick();
    check_eq("rst_level", 32'(btn_level), 32'h0);
    check_eq("rst_pulse", 32'(btn_pulse), 32'h0);
    check_eq("rst_sw", 32'(sw_stable), 32'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (btn_pulse != 2'b00) check_eq("t1_early_pulse", 32'(btn_pulse), 32'h0);
    end
    check_eq("t1_level_e6", 32'(btn_level), 32'h0);
    tick();
    check_eq("t1_pulse_e7", 32'(btn_pulse), 32'h3);
    check_eq("t1_level_e7", 32'(btn_level), 32'h3);
    check_eq("t1_sw_e7", 32'(sw_stable), 32'hFF);
    tick();
    check_eq("t1_pulse_e8", 32'(btn_pulse), 32'h0);
    check_eq("t1_level_e8", 32'(btn_level), 32'h3);
    btn_raw = 2'b00;
    sw_raw  = 8'h00;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (btn_pulse != 2'b00) check_eq("t1_release_pulse", 32'(btn_pulse), 32'h0);
    end
    check_eq("t1_released", 32'(btn_level), 32'h0);
    check_eq("t1_sw_zero", 32'(sw_stable), 32'h00);

    // 2: clean press held 50 cycles
    btn_raw[0] = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (btn_pulse[0]) pulses++;
      if (e == 6) check_eq("t2_pulse_e6", 32'(btn_pulse), 32'h0);
      if (e == 7) begin
        check_eq("t2_pulse_e7", 32'(btn_pulse), 32'h1);
        check_eq("t2_level_e7", 32'(btn_level), 32'h1);
      end
    end
    check_eq("t2_pulse_count", 32'(pulses), 32'd1);
    check_eq("t2_level_held", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    check_eq("t2_released", 32'(btn_level), 32'h0);

    // 3: bouncing press 1,0,1,1,0 then steady 1
    pulses = 0;
    btn_raw[0] = 1'b1; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b0; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b1; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b1; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b0; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (btn_pulse[0]) pulses++;
      if (e == 6) check_eq("t3_pulse_e6", 32'(btn_pulse), 32'h0);
      if (e == 7) check_eq("t3_pulse_e7", 32'(btn_pulse), 32'h1);
    end
    check_eq("t3_pulse_count", 32'(pulses), 32'd1);

    // 4: bouncing release 0,1,0 then steady 0
    pulses = 0;
    btn_raw[0] = 1'b0; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b1; tick(); if (btn_pulse[0]) pulses++;
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (btn_pulse[0]) pulses++;
      if (e == 6) check_eq("t4_level_e6", 32'(btn_level), 32'h1);
      if (e == 7) check_eq("t4_level_e7", 32'(btn_level), 32'h0);
    end
    check_eq("t4_no_pulse", 32'(pulses), 32'd0);

    // 5: switch bus 00 -> A5 with bit 0 glitching for two cycles
    bad_sw = 0;
    sw_raw = 8'hA5; tick(); if (sw_stable != 8'h00) bad_sw++;
    sw_raw = 8'hA4; tick(); if (sw_stable != 8'h00) bad_sw++;
    sw_raw = 8'hA4; tick(); if (sw_stable != 8'h00) bad_sw++;
    sw_raw = 8'hA5;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) check_eq("t5_sw_e6", 32'(sw_stable), 32'h00);
      if (e == 7) check_eq("t5_sw_e7", 32'(sw_stable), 32'hA5);
      if (e < 7 && sw_stable != 8'h00) bad_sw++;
      if (e >= 7 && sw_stable != 8'hA5) bad_sw++;
    end
    check_eq("t5_no_intermediate", 32'(bad_sw), 32'd0);

    // 6: reset asserted mid press-check, button held through release of reset
    pulses = 0;
    btn_raw[0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (btn_pulse[0]) pulses++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_level", 32'(btn_level), 32'h0);
    check_eq("t6_rst_pulse", 32'(btn_pulse), 32'h0);
    check_eq("t6_rst_sw", 32'(sw_stable), 32'h00);
    tick(); if (btn_pulse[0]) pulses++;
    tick(); if (btn_pulse[0]) pulses++;
    check_eq("t6_pulse_before_release", 32'(pulses), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (btn_pulse[0]) pulses++;
      if (e == 6) check_eq("t6_pulse_e6", 32'(btn_pulse), 32'h0);
      if (e == 7) begin
        check_eq("t6_pulse_e7", 32'(btn_pulse), 32'h1);
        check_eq("t6_level_e7", 32'(btn_level), 32'h1);
        check_eq("t6_sw_e7", 32'(sw_stable), 32'hA5);
      end
    end
    check_eq("t6_pulse_count", 32'(pulses), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
